// File: rtl/zmod_pkg.sv
// Shared types and defaults for the Zmod receive deserializer.
// Holds the alignment FSM encoding, the default training word and the word type.
package zmod_pkg;

  localparam int         WORD_W_DEF    = 8;
  localparam logic [7:0] TRAIN_PAT_DEF = 8'hA5;

  typedef logic [WORD_W_DEF-1:0] zmod_word_t;

  typedef enum logic [1:0] {
    HUNT,
    SETTLE,
    VERIFY,
    LOCKED
  } zmod_state_e;

endpackage

// File: rtl/zmod_bitslip_gearbox.sv
// Serial-to-parallel gearbox with a slip input; word_vld/word_dat are combinational
// in the cycle that samples a word's last bit. No backpressure: a word is offered every WORD_W cycles.
module zmod_bitslip_gearbox #(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sdata_in,
  input  logic              slip,
  output logic              word_vld,
  output logic [WORD_W-1:0] word_dat
);

  localparam int             CNT_W    = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);

  logic [WORD_W-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // A slip freezes the counter for one cycle, pushing the word boundary one bit later.
  always_comb begin
    sr_d  = {sr_q[WORD_W-2:0], sdata_in};
    cnt_d = cnt_q;
    if (!slip) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign word_vld = (cnt_q == CNT_LAST);
  assign word_dat = sr_d;

endmodule

// File: rtl/zmod_rx_deser.sv
// Bit-clock deserializer that aligns on a training word, then emits parallel words.
// rx_valid one cycle after the last bit's edge; no backpressure (one word per WORD_W cycles).
module zmod_rx_deser
  import zmod_pkg::*;
#(
  parameter int                WORD_W     = $bits(zmod_word_t),
  parameter logic [WORD_W-1:0] TRAIN_PAT  = TRAIN_PAT_DEF,
  parameter int                VERIFY_CNT = 16,
  parameter int                LOSS_CNT   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      sdata_in,
  input  logic                      train_en,
  output logic [WORD_W-1:0]         rx_data,
  output logic                      rx_valid,
  output logic                      aligned,
  output logic [$clog2(WORD_W)-1:0] slip_count,
  output logic [15:0]               err_count
);

  localparam int SC_W = $clog2(WORD_W);
  localparam int VC_W = $clog2(VERIFY_CNT + 1);
  localparam int MC_W = $clog2(LOSS_CNT + 1);

  logic              word_vld;
  logic [WORD_W-1:0] word_dat;
  logic              match;

  zmod_state_e       state_q, state_d;
  logic [VC_W-1:0]   vcnt_q, vcnt_d;
  logic [MC_W-1:0]   miss_q, miss_d;
  logic              slip_q, slip_d;
  logic [SC_W-1:0]   slip_cnt_q, slip_cnt_d;
  logic [15:0]       err_q, err_d;
  logic [WORD_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              aligned_q, aligned_d;

  zmod_bitslip_gearbox #(
    .WORD_W (WORD_W)
  ) u_gearbox (
    .clk      (clk),
    .reset    (reset),
    .sdata_in (sdata_in),
    .slip     (slip_q),
    .word_vld (word_vld),
    .word_dat (word_dat)
  );

  assign match = (word_dat == TRAIN_PAT);

  always_comb begin
    state_d    = state_q;
    vcnt_d     = vcnt_q;
    miss_d     = miss_q;
    slip_d     = 1'b0;
    slip_cnt_d = slip_cnt_q;
    err_d      = err_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;

    if (word_vld) begin
      case (state_q)
        HUNT: begin
          if (train_en) begin
            if (match) begin
              state_d = VERIFY;
              vcnt_d  = VC_W'(1);
            end else begin
              slip_d  = 1'b1;
              state_d = SETTLE;
            end
          end
        end
        // The word straddling a fresh slip is discarded before comparing again.
        SETTLE: begin
          if (train_en) begin
            state_d = HUNT;
          end
        end
        VERIFY: begin
          if (train_en) begin
            if (!match) begin
              slip_d  = 1'b1;
              state_d = SETTLE;
              vcnt_d  = '0;
            end else if (vcnt_q == VC_W'(VERIFY_CNT - 1)) begin
              state_d = LOCKED;
              vcnt_d  = '0;
              miss_d  = '0;
            end else begin
              vcnt_d = vcnt_q + 1'b1;
            end
          end
        end
        LOCKED: begin
          rx_valid_d = 1'b1;
          rx_data_d  = word_dat;
          if (train_en) begin
            if (match) begin
              miss_d = '0;
            end else begin
              miss_d = miss_q + 1'b1;
              if (err_q != 16'hFFFF) begin
                err_d = err_q + 1'b1;
              end
              // Losing lock withholds the offending word entirely.
              if (miss_d == MC_W'(LOSS_CNT)) begin
                state_d    = HUNT;
                miss_d     = '0;
                rx_valid_d = 1'b0;
                rx_data_d  = rx_data_q;
              end
            end
          end
        end
      endcase
    end

    if (slip_d) begin
      slip_cnt_d = (slip_cnt_q == SC_W'(WORD_W - 1)) ? '0 : slip_cnt_q + 1'b1;
    end

    aligned_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= HUNT;
      vcnt_q     <= '0;
      miss_q     <= '0;
      slip_q     <= 1'b0;
      slip_cnt_q <= '0;
      err_q      <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      aligned_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      vcnt_q     <= vcnt_d;
      miss_q     <= miss_d;
      slip_q     <= slip_d;
      slip_cnt_q <= slip_cnt_d;
      err_q      <= err_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      aligned_q  <= aligned_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign aligned    = aligned_q;
  assign slip_count = slip_cnt_q;
  assign err_count  = err_q;

endmodule
